spi_slave_reg_bridge: RTL and testbench
=======================================

// Module: spi_slave_reg_bridge
// PURPOSE
//  SPI target (slave) that answers the fabric's CoreSPI master: Motorola framing, 8-bit frames.
//  Decodes command byte {RW,ADDR[6:0]}, then bursts data to/from a simple byte register bus.
//  Used as the far-end responder for SPI bring-up and as a loopback target for the master.
//  All SPI pins are oversampled in the PCLK domain. There is no second clock.
// PARAMETERS
//  CFG_MOT_MODE  3  SPI mode 0..3: bit1=CPOL (idle SCLK level), bit0=CPHA (0: sample leading edge)
//  SYNC_STAGES   2  synchronizer flops on SPISCLK/SPISSN/SPIMOSI (2 or 3)
// PORTS
//  PCLK        in   1  system clock; SCLK period must be >= 16 PCLK periods
//  PRESETN     in   1  asynchronous active-low reset
//  SPISCLK     in   1  SPI clock from the master (asynchronous)
//  SPISSN      in   1  slave select, active low (asynchronous)
//  SPIMOSI     in   1  master-out data
//  SPIMISO     out  1  slave-out data, MSB first
//  SPIMISO_OE  out  1  output enable for the MISO pad; high while SS is active (synced)
//  REG_ADDR    out  7  register address, stable from the REG_RE/REG_WE pulse until the next update
//  REG_WDATA   out  8  write data, valid while REG_WE=1
//  REG_WE      out  1  one-cycle write strobe
//  REG_RE      out  1  one-cycle read strobe
//  REG_RDATA   in   8  read data; valid on the cycle after REG_RE (1-cycle latency)
//  BUSY        out  1  synced SS active
//  FRAME_ERR   out  1  one-cycle pulse: SS deasserted with partial byte (bit count 1..7)
// BEHAVIOUR
//  Reset: all outputs 0, REG_ADDR=0, state IDLE, shift/bit counter cleared.
//  Synchronization: SYNC_STAGES flops on each pin; edges are detected on the synced SCLK.
//  Edge roles: leading = transition away from CPOL. CPHA=0: sample on leading, shift on trailing.
//    CPHA=1: shift on leading, sample on trailing.
//  MSB timing: CPHA=0: byte0 MSB driven when synced SS falls; next-byte MSB on the 8th trailing edge.
//    CPHA=1: every byte's MSB driven on its first leading edge.
//  Bit counter 0..7: increments on each sample edge. Wraps 7->0 and raises byte_done (1 cycle).
//  FSM IDLE: SS falling -> CMD, MISO shift reg=0x00.
//  FSM CMD: on byte_done latch ADDR=rx[6:0]. rx[7]=1 -> RDATA, REG_RE pulse next cycle.
//    rx[7]=0 -> WDATA.
//  FSM WDATA: each byte_done -> REG_WE=1 for 1 cycle with REG_WDATA=rx, REG_ADDR=ADDR.
//    After the strobe, ADDR increments.
//  FSM RDATA: REG_RE at byte_done+1. REG_RDATA captured at byte_done+2 and loaded into the TX shift
//    reg at byte_done+3, before the next MSB shift edge (guaranteed by >=16 PCLK SCLK period).
//    ADDR increments after each REG_RE, so the next byte is prefetched.
//  Read data is one byte behind the command: MISO during the command byte is 0x00.
//  ADDR wraps 0x7F -> 0x00 in both burst directions.
//  MOSI bytes received in RDATA are ignored. MISO in WDATA/CMD shifts 0x00.
//  SS deassert (any state): return to IDLE the next cycle, clear bit counter, SPIMISO_OE=0, SPIMISO=0.
//    Partial byte: FRAME_ERR pulse and no REG_WE for that byte.
//    Completed bytes already written stay written.
//  SS deassert and byte_done in the same cycle: the byte completes (WE/RE issued), with no FRAME_ERR.
//  SCLK edges while SS is inactive are ignored.
//  PRESETN low mid-transfer: immediate return to reset values. The next SS fall starts clean.
//  Outputs are registered. No combinational path from SPI pins to any output.
// TESTING
//  T1 mode3, SS low, send 0x05,0xA5, SS high -> one REG_WE, REG_ADDR=0x05, REG_WDATA=0xA5.
//    No FRAME_ERR.
//  T2 burst write 0x7F,0x11,0x22,0x33 -> REG_WE x3 at ADDR 0x7F,0x00,0x01 with data 11,22,33.
//  T3 read 0x90 then 3 dummy bytes, model REG_RDATA=addr^0x3C -> MISO bytes 00,2C,2D,2E.
//    REG_RE at addr 0x10,0x11,0x12,0x13.
//  T4 write cmd 0x02 then 4 data bits, SS high -> FRAME_ERR pulse once, no REG_WE.
//    Next transaction T1 passes.
//  T5 PRESETN low mid-read burst -> all outputs 0 within the async assertion.
//    After release, T3 repeats identically.
//  T6 CFG_MOT_MODE=0 rerun T1+T3 at SCLK=PCLK/16 -> same register traffic and MISO bytes.

Source files
------------

// File: rtl/spi_slave_reg_bridge.sv
// SPI target bridging {RW,ADDR[6:0]} command frames to a byte-wide register bus.
// All SPI pins are oversampled in the PCLK domain; outputs are registered.
module spi_slave_reg_bridge #(
    parameter int unsigned CFG_MOT_MODE = 3,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       SPISCLK,
    input  logic       SPISSN,
    input  logic       SPIMOSI,
    output logic       SPIMISO,
    output logic       SPIMISO_OE,
    output logic [6:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WE,
    output logic       REG_RE,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY,
    output logic       FRAME_ERR
);

    localparam bit CPOL = ((CFG_MOT_MODE >> 1) & 1) != 0;
    localparam bit CPHA = (CFG_MOT_MODE & 1) != 0;

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
    logic       sclk_prev_q, ssn_prev_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic       miso_q, ss_act_q, we_q, re_q, re_dly_q, fe_q;
    logic       we_d, re_d, fe_d;

    logic sclk_s, ssn_s, mosi_s;
    logic rise, fall, lead, trail, edge_en, sample, shift;
    logic ss_fall, ss_rise, byte_done;
    logic [7:0] rx_full;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            ssn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            ssn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPISCLK};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], SPISSN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPIMOSI};
            sclk_prev_q <= sclk_s;
            ssn_prev_q  <= ssn_s;
        end
    end

    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        ssn_s     = ssn_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        rise      = sclk_s & ~sclk_prev_q;
        fall      = ~sclk_s & sclk_prev_q;
        lead      = CPOL ? fall : rise;
        trail     = CPOL ? rise : fall;
        // Gate on the previous SS sample so an edge coincident with SS rising still counts.
        edge_en   = ~ssn_prev_q;
        sample    = edge_en & (CPHA ? trail : lead);
        shift     = edge_en & (CPHA ? lead : trail);
        ss_fall   = ssn_prev_q & ~ssn_s;
        ss_rise   = ~ssn_prev_q & ssn_s;
        byte_done = sample && (bit_cnt_q == 3'd7);
        rx_full   = {rx_q, mosi_s};
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ss_fall) state_d = StCmd;
            StCmd:   if (byte_done) state_d = rx_full[7] ? StRdata : StWdata;
            default: ;
        endcase
        // A byte completing on the SS-release cycle still gets its strobe first.
        if (ssn_s && !byte_done) state_d = StIdle;
    end

    always_comb begin
        we_d = byte_done && (state_q == StWdata);
        re_d = byte_done && (((state_q == StCmd) && rx_full[7]) || (state_q == StRdata));
        fe_d = ss_rise && (bit_cnt_q != 3'd0) && !byte_done;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            bit_cnt_q <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            ss_act_q  <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            re_dly_q  <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            ss_act_q <= ~ssn_s;
            we_q     <= we_d;
            re_q     <= re_d;
            re_dly_q <= re_q;
            fe_q     <= fe_d;

            if (ssn_s)       bit_cnt_q <= 3'd0;
            else if (sample) bit_cnt_q <= bit_cnt_q + 3'd1;

            if (sample) rx_q <= rx_full[6:0];
            if (we_d)   wdata_q <= rx_full;

            if (byte_done && (state_q == StCmd)) addr_q <= rx_full[6:0];
            else if (we_q || re_q)               addr_q <= addr_q + 7'd1;

            // Read data lands in the shift register well before the next MSB shift edge.
            if (ssn_s || ss_fall) begin
                tx_q   <= 8'd0;
                miso_q <= 1'b0;
            end else if (re_dly_q) begin
                tx_q <= REG_RDATA;
            end else if (shift) begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
            end
        end
    end

    assign SPIMISO    = miso_q;
    assign SPIMISO_OE = ss_act_q;
    assign BUSY       = ss_act_q;
    assign REG_ADDR   = addr_q;
    assign REG_WDATA  = wdata_q;
    assign REG_WE     = we_q;
    assign REG_RE     = re_q;
    assign FRAME_ERR  = fe_q;

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Bench: bit-banged SPI master driving a mode-3 and a mode-0 bridge, with a register-bus
// scoreboard and a table of transactions.
module tb_spi_slave_reg_bridge;

    localparam int H = 8;  // SCLK half period in PCLK cycles

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       sph = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       cur_sel = 1'b0;
    logic       mon_en = 1'b1;
    logic       sclk3, ssn3, sclk0, ssn0, cur_miso;

    logic       miso3, oe3, we3, re3, busy3, fe3;
    logic [6:0] addr3;
    logic [7:0] wdata3, rdata3 = 8'h00;
    logic       miso0, oe0, we0, re0, busy0, fe0;
    logic [6:0] addr0;
    logic [7:0] wdata0, rdata0 = 8'h00;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;

    typedef struct {
        bit   is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } op_t;
    op_t exp_q[$];

    typedef struct {
        bit          sel;   // 0: mode-3 DUT, 1: mode-0 DUT
        int          nbits;
        logic [39:0] mosi;
        logic [39:0] miso;
        int          fe;
    } vec_t;
    localparam int NV = 10;
    vec_t vecs [NV];

    always #5 pclk = ~pclk;

    assign sclk3    = ~sph;
    assign sclk0    = sph;
    assign ssn3     = cur_sel ? 1'b1 : ss_n;
    assign ssn0     = cur_sel ? ss_n : 1'b1;
    assign cur_miso = cur_sel ? miso0 : miso3;

    spi_slave_reg_bridge #(.CFG_MOT_MODE(3), .SYNC_STAGES(2)) u_dut3 (
        .PCLK(pclk), .PRESETN(presetn), .SPISCLK(sclk3), .SPISSN(ssn3), .SPIMOSI(mosi),
        .SPIMISO(miso3), .SPIMISO_OE(oe3), .REG_ADDR(addr3), .REG_WDATA(wdata3),
        .REG_WE(we3), .REG_RE(re3), .REG_RDATA(rdata3), .BUSY(busy3), .FRAME_ERR(fe3)
    );

    spi_slave_reg_bridge #(.CFG_MOT_MODE(0), .SYNC_STAGES(2)) u_dut0 (
        .PCLK(pclk), .PRESETN(presetn), .SPISCLK(sclk0), .SPISSN(ssn0), .SPIMOSI(mosi),
        .SPIMISO(miso0), .SPIMISO_OE(oe0), .REG_ADDR(addr0), .REG_WDATA(wdata0),
        .REG_WE(we0), .REG_RE(re0), .REG_RDATA(rdata0), .BUSY(busy0), .FRAME_ERR(fe0)
    );

    // Register file model: data = addr ^ 0x3C, one cycle after REG_RE.
    always @(posedge pclk) begin
        if (re3) rdata3 <= {1'b0, addr3} ^ 8'h3C;
        if (re0) rdata0 <= {1'b0, addr0} ^ 8'h3C;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_op(input logic we, input logic [6:0] addr, input logic [7:0] wdata);
        op_t op;
        check("strobe_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
            op = exp_q.pop_front();
            check("strobe_kind_is_write", {31'd0, we}, {31'd0, op.is_wr});
            check("strobe_addr", {25'd0, addr}, {25'd0, op.addr});
            if (we) check("strobe_wdata", {24'd0, wdata}, {24'd0, op.data});
        end
    endtask

    always @(negedge pclk) begin
        if (mon_en) begin
            if (we3 || re3) check_op(we3, addr3, wdata3);
            if (we0 || re0) check_op(we0, addr0, wdata0);
        end
        if (fe3 || fe0) fe_cnt++;
    end

    function automatic vec_t mk(bit s, int n, logic [39:0] mo, logic [39:0] mi, int fe);
        vec_t v;
        v.sel = s; v.nbits = n; v.mosi = mo; v.miso = mi; v.fe = fe;
        return v;
    endfunction

    // Expected bus traffic: reads strobe after the command and every full dummy byte,
    // writes strobe for every full data byte; addresses wrap at 7 bits.
    task automatic push_expected(input vec_t v);
        op_t op;
        int nfull;
        logic [7:0] cmd;
        nfull = v.nbits / 8;
        cmd = v.mosi[39:32];
        if (nfull == 0) return;
        if (cmd[7]) begin
            for (int i = 0; i < nfull; i++) begin
                op.is_wr = 1'b0; op.addr = cmd[6:0] + 7'(i); op.data = 8'h00;
                exp_q.push_back(op);
            end
        end else begin
            for (int i = 1; i < nfull; i++) begin
                op.is_wr = 1'b1; op.addr = cmd[6:0] + 7'(i - 1);
                op.data = v.mosi[39 - 8*i -: 8];
                exp_q.push_back(op);
            end
        end
    endtask

    task automatic spi_xfer(input bit sel, input int nbits, input logic [39:0] mo,
                            output logic [39:0] mi);
        bit cpha;
        cpha = !sel;
        mi = '0;
        cur_sel = sel;
        @(negedge pclk);
        ss_n = 1'b0;
        if (!cpha) mosi = mo[39];
        repeat (H) @(negedge pclk);
        check("busy_oe_active", sel ? {30'd0, busy0, oe0} : {30'd0, busy3, oe3}, 32'd3);
        for (int i = 0; i < nbits; i++) begin
            sph = 1'b1;
            if (cpha) mosi = mo[39 - i];
            else      mi[39 - i] = cur_miso;
            repeat (H) @(negedge pclk);
            sph = 1'b0;
            if (cpha)              mi[39 - i] = cur_miso;
            else if (i + 1 < nbits) mosi = mo[38 - i];
            repeat (H) @(negedge pclk);
        end
        ss_n = 1'b1;
        repeat (H) @(negedge pclk);
        check("idle_busy_oe_miso", sel ? {29'd0, busy0, oe0, miso0} : {29'd0, busy3, oe3, miso3},
              32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [39:0] rx;
        v = vecs[idx];
        fe_cnt = 0;
        push_expected(v);
        spi_xfer(v.sel, v.nbits, v.mosi, rx);
        for (int b = 0; b < v.nbits / 8; b++)
            check($sformatf("miso_vec%0d_byte%0d", idx, b), {24'd0, rx[39 - 8*b -: 8]},
                  {24'd0, v.miso[39 - 8*b -: 8]});
        repeat (4) @(negedge pclk);
        check($sformatf("frame_err_count_vec%0d", idx), fe_cnt, v.fe);
        check($sformatf("missing_strobes_vec%0d", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [31:0] all_outs3();
        return {11'd0, miso3, oe3, we3, re3, busy3, fe3, addr3, wdata3};
    endfunction

    function automatic logic [31:0] all_outs0();
        return {11'd0, miso0, oe0, we0, re0, busy0, fe0, addr0, wdata0};
    endfunction

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [39:0] rx5;

        vecs[0] = mk(0, 16, 40'h05A5000000, 40'h0000000000, 0);  // single write
        vecs[1] = mk(0, 32, 40'h7F11223300, 40'h0000000000, 0);  // burst write, addr wrap
        vecs[2] = mk(0, 32, 40'h9055AAFF00, 40'h002C2D2E00, 0);  // burst read, MOSI ignored
        vecs[3] = mk(0, 12, 40'h02A0000000, 40'h0000000000, 1);  // partial data byte
        vecs[4] = mk(0, 16, 40'h05A5000000, 40'h0000000000, 0);
        vecs[5] = mk(0, 16, 40'h85C3000000, 40'h0039000000, 0);
        vecs[6] = mk(1, 16, 40'h05A5000000, 40'h0000000000, 0);  // mode 0
        vecs[7] = mk(1, 32, 40'h9055AAFF00, 40'h002C2D2E00, 0);
        vecs[8] = mk(1, 24, 40'hFF00000000, 40'h00433C0000, 0);  // read wrap 7F -> 00
        vecs[9] = mk(1, 21, 40'h1234560000, 40'h0000000000, 1);  // write byte kept, then partial

        repeat (3) @(negedge pclk);
        check("reset_outputs_mode3", all_outs3(), 32'd0);
        check("reset_outputs_mode0", all_outs0(), 32'd0);
        presetn = 1'b1;
        repeat (5) @(negedge pclk);
        check("post_reset_outputs_mode3", all_outs3(), 32'd0);
        check("post_reset_outputs_mode0", all_outs0(), 32'd0);

        for (int v = 0; v < NV; v++) run_vec(v);

        // SCLK toggling with SS inactive must not advance anything.
        cur_sel = 1'b0;
        fe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            sph = ~sph;
            repeat (H) @(negedge pclk);
        end
        check("idle_sclk_frame_err", fe_cnt, 0);
        check("idle_sclk_busy", {31'd0, busy3}, 32'd0);
        run_vec(0);

        // Reset asserted in the middle of a read burst.
        mon_en = 1'b0;
        fork
            spi_xfer(0, 32, 40'h9055AAFF00, rx5);
            begin
                repeat (300) @(negedge pclk);
                #2 presetn = 1'b0;
                #1 check("async_reset_outputs_mode3", all_outs3(), 32'd0);
                check("async_reset_outputs_mode0", all_outs0(), 32'd0);
            end
        join
        repeat (4) @(negedge pclk);
        check("held_reset_outputs_mode3", all_outs3(), 32'd0);
        presetn = 1'b1;
        repeat (4) @(negedge pclk);
        exp_q.delete();
        mon_en = 1'b1;
        run_vec(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
